checker_mode_read: RTL and testbench

//  Checker "read" mode engine; sits directly downstream of the checker CSR control interface.
//  - Consumes mode_mode / mode_start / mode_addr.
//  - Reads NWORDS consecutive 64-bit words from memory over a req/gnt + rvalid port.
//  - Returns their XOR checksum on mode_data and pulses mode_end.
//  - Raises mode_irq plus a sticky mode_error on a failed read, held until mode_ack.

---
 rtl/checker_mode_read_pkg.sv | 23 ++
 rtl/checker_mode_read_timer.sv | 39 +++
 rtl/checker_mode_read.sv | 191 +++++++++++++++++++
 tb/tb_checker_mode_read.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/checker_mode_read_pkg.sv
// rtl/checker_mode_read_pkg.sv - mode encodings, FSM states and address helper for the read-mode engine
package checker_mode_read_pkg;

   // Checker mode encodings shared with the CSR control interface
   localparam logic [1:0] CHECKER_MODE_DUMMY = 2'd0;
   localparam logic [1:0] CHECKER_MODE_READ  = 2'd1;

   // Byte distance between consecutive 64-bit words
   localparam logic [63:0] ADDR_STEP = 64'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Force a byte address down to its containing 64-bit word
   function automatic logic [63:0] align_word(input logic [63:0] a);
      return a & ~64'h7;
   endfunction

endpackage

// File: rtl/checker_mode_read_timer.sv
// rtl/checker_mode_read_timer.sv - load/enable/expire down-counter bounding memory waits
module checker_mode_read_timer #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam int unsigned W = $clog2(TIMEOUT + 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Reload on every state change, otherwise count down while the engine is waiting
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = W'(TIMEOUT);
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Expire on the TIMEOUT-th enabled cycle after a load; independent of load to avoid a loop
   assign expire = en && (cnt_q == W'(1));

   // Counter register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/checker_mode_read.sv
// rtl/checker_mode_read.sv - read-mode engine: XOR checksum of NWORDS words; optional CHECKER_MODE_TIMEOUT_EN
module checker_mode_read
   import checker_mode_read_pkg::*;
#(
   parameter int unsigned NWORDS = 4
`ifdef CHECKER_MODE_TIMEOUT_EN
   , parameter int unsigned TIMEOUT = 1023
`endif
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [1:0]  mode_mode,
   input  logic        mode_start,
   input  logic [63:0] mode_addr,
   output logic        mode_end,
   output logic [63:0] mode_data,
   output logic        mode_irq,
   input  logic        mode_ack,
   output logic        mode_error,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata
);

   state_e      state_q, state_d;
   logic [63:0] addr_q, addr_d;
   logic [7:0]  count_q, count_d;
   logic [63:0] acc_q, acc_d;
   logic [63:0] data_q, data_d;
   logic        end_q, end_d;
   logic        err_q, err_d;
   logic        irq_q, irq_d;
   logic        req_q, req_d;
   logic        owed_q, owed_d;

   logic        timeout_hit;
   logic        live_rvalid;
   logic        set_err;
   logic        last_word;

`ifdef CHECKER_MODE_TIMEOUT_EN
   logic tmr_load;
   logic tmr_en;

   assign tmr_load = (state_d != state_q);
   assign tmr_en   = (state_q == ST_REQ) || (state_q == ST_WAIT);

   checker_mode_read_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .load    (tmr_load),
      .en      (tmr_en),
      .expire  (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // A response owed to an aborted run is swallowed; only the remaining ones are live
   assign live_rvalid = mem_rvalid && !owed_q;
   assign last_word   = (count_q == 8'(NWORDS - 1));

   // Next-state, datapath and error-flag computation
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      acc_d   = acc_q;
      data_d  = data_q;
      end_d   = 1'b0;
      err_d   = err_q;
      irq_d   = irq_q;
      owed_d  = owed_q;
      set_err = 1'b0;

      if (mem_rvalid && owed_q) begin
         owed_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (mode_start && (mode_mode == CHECKER_MODE_READ)) begin
               state_d = ST_REQ;
               addr_d  = align_word(mode_addr);
               acc_d   = '0;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         ST_REQ: begin
            if (!mode_start) begin
               state_d = ST_IDLE;
               if (mem_gnt) begin
                  owed_d = 1'b1;
               end
            end else if (timeout_hit) begin
               state_d = ST_DONE;
               data_d  = acc_q;
               end_d   = 1'b1;
               set_err = 1'b1;
            end else if (mem_gnt) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!mode_start) begin
               state_d = ST_IDLE;
               owed_d  = !live_rvalid;
            end else if (live_rvalid) begin
               if (last_word) begin
                  state_d = ST_DONE;
                  data_d  = acc_q ^ mem_rdata;
                  end_d   = 1'b1;
               end else begin
                  state_d = ST_REQ;
                  acc_d   = acc_q ^ mem_rdata;
                  addr_d  = addr_q + ADDR_STEP;
                  count_d = count_q + 8'd1;
               end
            end else if (timeout_hit) begin
               state_d = ST_DONE;
               data_d  = acc_q;
               end_d   = 1'b1;
               set_err = 1'b1;
               owed_d  = 1'b1;
            end
         end
         ST_DONE: begin
            if (!mode_start) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Unsolicited data during an active or finished run is a protocol error; in IDLE it
      // may be a straggler from before a reset, so it is ignored there
      if (live_rvalid && ((state_q == ST_REQ) || (state_q == ST_DONE))) begin
         set_err = 1'b1;
      end

      if (set_err) begin
         err_d = 1'b1;
         irq_d = 1'b1;
      end else if (mode_ack) begin
         err_d = 1'b0;
         irq_d = 1'b0;
      end

      req_d = (state_d == ST_REQ);
   end

   // State and registered outputs
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         count_q <= '0;
         acc_q   <= '0;
         data_q  <= '0;
         end_q   <= 1'b0;
         err_q   <= 1'b0;
         irq_q   <= 1'b0;
         req_q   <= 1'b0;
         owed_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         end_q   <= end_d;
         err_q   <= err_d;
         irq_q   <= irq_d;
         req_q   <= req_d;
         owed_q  <= owed_d;
      end
   end

   assign mode_end   = end_q;
   assign mode_data  = data_q;
   assign mode_irq   = irq_q;
   assign mode_error = err_q;
   assign mem_req    = req_q;
   assign mem_addr   = addr_q;

endmodule

// File: tb/tb_checker_mode_read.sv
// tb/tb_checker_mode_read.sv - directed self-checking bench for checker_mode_read
module tb_checker_mode_read;
   import checker_mode_read_pkg::*;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [1:0]  mode_mode = 2'd0;
   logic        mode_start = 1'b0;
   logic [63:0] mode_addr = '0;
   logic        mode_end;
   logic [63:0] mode_data;
   logic        mode_irq;
   logic        mode_ack = 1'b0;
   logic        mode_error;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;

   int n_cmp = 0;
   int n_bad = 0;
   int end_cnt = 0;

`ifdef CHECKER_MODE_TIMEOUT_EN
   checker_mode_read #(.NWORDS(4), .TIMEOUT(16)) dut (
`else
   checker_mode_read #(.NWORDS(4)) dut (
`endif
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .mode_mode  (mode_mode),
      .mode_start (mode_start),
      .mode_addr  (mode_addr),
      .mode_end   (mode_end),
      .mode_data  (mode_data),
      .mode_irq   (mode_irq),
      .mode_ack   (mode_ack),
      .mode_error (mode_error),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) begin
      #1;
      if (mode_end) end_cnt++;
   end

   task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge sys_clk);
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mem_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // One word: grant in the request cycle, data in the following cycle
   task automatic do_word(input string tag, input logic [63:0] exp_addr, input logic [63:0] data);
      bit ok;
      wait_req(ok);
      chk_val({tag, "_req"}, 64'(ok), 64'd1);
      if (!ok) return;
      chk_val({tag, "_addr"}, mem_addr, exp_addr);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = data;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic body4(input string tag, input logic [63:0] base, input bit chg_mode,
                        input logic [63:0] w0, input logic [63:0] w1,
                        input logic [63:0] w2, input logic [63:0] w3,
                        input logic [63:0] exp_sum);
      int e0;
      e0 = end_cnt;
      do_word({tag, "_w0"}, base, w0);
      if (chg_mode) mode_mode = 2'd2;
      do_word({tag, "_w1"}, base + 64'd8, w1);
      do_word({tag, "_w2"}, base + 64'd16, w2);
      do_word({tag, "_w3"}, base + 64'd24, w3);
      chk_val({tag, "_end"}, 64'(mode_end), 64'd1);
      chk_val({tag, "_data"}, mode_data, exp_sum);
      tick();
      chk_val({tag, "_endpulse"}, 64'(mode_end), 64'd0);
      chk_val({tag, "_endcnt"}, 64'(end_cnt - e0), 64'd1);
      chk_val({tag, "_err"}, 64'(mode_error), 64'd0);
      mode_start = 1'b0;
      tick();
      tick();
   endtask

   task automatic run4(input string tag, input logic [63:0] addr, input logic [63:0] base,
                       input bit chg_mode,
                       input logic [63:0] w0, input logic [63:0] w1,
                       input logic [63:0] w2, input logic [63:0] w3,
                       input logic [63:0] exp_sum);
      mode_mode = CHECKER_MODE_READ;
      mode_addr = addr;
      mode_start = 1'b1;
      body4(tag, base, chg_mode, w0, w1, w2, w3, exp_sum);
   endtask

   initial begin
      int e0;
      bit ok;
      int lat;

      // Reset state
      repeat (2) tick();
      chk_val("rst_req", 64'(mem_req), 64'd0);
      chk_val("rst_addr", mem_addr, 64'd0);
      chk_val("rst_end", 64'(mode_end), 64'd0);
      chk_val("rst_data", mode_data, 64'd0);
      chk_val("rst_irq", 64'(mode_irq), 64'd0);
      chk_val("rst_err", 64'(mode_error), 64'd0);
      sys_rst = 1'b0;
      tick();

      // Basic run: 1^2^4^8 = 0xF
      run4("t1", 64'h1000, 64'h1000, 1'b0, 64'h1, 64'h2, 64'h4, 64'h8, 64'hF);

      // Unaligned base, mode changed mid-run
      run4("t2a", 64'h1005, 64'h1000, 1'b1, 64'h1, 64'h10, 64'h100, 64'h1000, 64'h1111);

      // Address wrap: F..F8 -> 0 -> 8 -> 10
      run4("t2b", 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0,
           64'hFFFF_0000_0000_0000, 64'h0000_FFFF_0000_0000,
           64'h1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_0000_0001);

      // Abort during second WAIT, then restart with the owed response arriving in REQ
      e0 = end_cnt;
      mode_mode = CHECKER_MODE_READ;
      mode_addr = 64'h2000;
      mode_start = 1'b1;
      do_word("t3_w0", 64'h2000, 64'h5);
      wait_req(ok);
      chk_val("t3_req1", 64'(ok), 64'd1);
      chk_val("t3_addr1", mem_addr, 64'h2008);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      mode_start = 1'b0;
      tick();
      chk_val("t3_abort_req", 64'(mem_req), 64'd0);
      chk_val("t3_abort_data", mode_data, 64'h7FFF_FFFF_0000_0001);
      chk_val("t3_abort_end", 64'(end_cnt - e0), 64'd0);
      mode_start = 1'b1;
      tick();
      mem_rvalid = 1'b1;
      mem_rdata = 64'hDEAD_BEEF;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      chk_val("t3_late_err", 64'(mode_error), 64'd0);
      chk_val("t3_late_irq", 64'(mode_irq), 64'd0);
      body4("t3r", 64'h2000, 1'b0, 64'h3, 64'h5, 64'h9, 64'h11, 64'h1E);

      // Protocol error: rvalid in REQ; ack collides with a new error; start clears error only
      mode_mode = CHECKER_MODE_READ;
      mode_addr = 64'h3000;
      mode_start = 1'b1;
      tick();
      mem_rvalid = 1'b1;
      tick();
      chk_val("pe_err", 64'(mode_error), 64'd1);
      chk_val("pe_irq", 64'(mode_irq), 64'd1);
      mode_ack = 1'b1;
      tick();
      chk_val("pe_ackcoll_irq", 64'(mode_irq), 64'd1);
      chk_val("pe_ackcoll_err", 64'(mode_error), 64'd1);
      mem_rvalid = 1'b0;
      tick();
      chk_val("pe_ack_irq", 64'(mode_irq), 64'd0);
      chk_val("pe_ack_err", 64'(mode_error), 64'd0);
      mode_ack = 1'b0;
      mem_rvalid = 1'b1;
      tick();
      mem_rvalid = 1'b0;
      mode_start = 1'b0;
      tick();
      mode_start = 1'b1;
      tick();
      chk_val("pe_start_err", 64'(mode_error), 64'd0);
      chk_val("pe_start_irq", 64'(mode_irq), 64'd1);
      mode_ack = 1'b1;
      tick();
      mode_ack = 1'b0;
      chk_val("pe_ack2_irq", 64'(mode_irq), 64'd0);
      body4("pe", 64'h3000, 1'b0, 64'h10, 64'h20, 64'h30, 64'h1, 64'h1);

      // Non-read mode: engine stays idle
      e0 = end_cnt;
      mode_mode = CHECKER_MODE_DUMMY;
      mode_addr = 64'h4000;
      mode_start = 1'b1;
      repeat (6) tick();
      chk_val("t5_req", 64'(mem_req), 64'd0);
      chk_val("t5_end", 64'(end_cnt - e0), 64'd0);
      chk_val("t5_err", 64'(mode_error), 64'd0);
      chk_val("t5_irq", 64'(mode_irq), 64'd0);
      mode_start = 1'b0;
      tick();

`ifdef CHECKER_MODE_TIMEOUT_EN
      // Grant never arrives: timeout after 16 cycles in REQ
      mode_mode = CHECKER_MODE_READ;
      mode_addr = 64'h5000;
      mode_start = 1'b1;
      tick();
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (mode_end) begin
            lat = i;
            break;
         end
      end
      chk_val("t4_latency", 64'(lat), 64'd16);
      chk_val("t4_err", 64'(mode_error), 64'd1);
      chk_val("t4_irq", 64'(mode_irq), 64'd1);
      chk_val("t4_data", mode_data, 64'd0);
      mode_start = 1'b0;
      mode_ack = 1'b1;
      tick();
      mode_ack = 1'b0;
      chk_val("t4_ack_err", 64'(mode_error), 64'd0);
      chk_val("t4_ack_irq", 64'(mode_irq), 64'd0);
      tick();
`else
      lat = 0;
`endif

      // Asynchronous reset while requesting
      mode_mode = CHECKER_MODE_READ;
      mode_addr = 64'h6000;
      mode_start = 1'b1;
      wait_req(ok);
      chk_val("t6_req_before", 64'(ok), 64'd1);
      #2;
      sys_rst = 1'b1;
      mode_start = 1'b0;
      #1;
      chk_val("t6_req_rst", 64'(mem_req), 64'd0);
      chk_val("t6_addr_rst", mem_addr, 64'd0);
      chk_val("t6_data_rst", mode_data, 64'd0);
      tick();
      sys_rst = 1'b0;
      mem_rvalid = 1'b1;
      tick();
      mem_rvalid = 1'b0;
      chk_val("t6_late_err", 64'(mode_error), 64'd0);
      run4("t6r", 64'h6000, 64'h6000, 1'b0, 64'hF0, 64'h0F, 64'h100, 64'h1, 64'h1FE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
